// File: rtl/abphase_stream_packer.sv
// Absolute-phase stream packer: tags pixels with sof/eol,
// buffers them in a FIFO and presents a valid/ready stream.
module abphase_stream_packer #(
  parameter int DATA_WIDTH    = 32,
  parameter int IMG_W         = 1280,
  parameter int IMG_H         = 1024,
  parameter int FIFO_DEPTH    = 16,
  parameter int OVF_CNT_WIDTH = 16,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_vsync,
  input  logic [DATA_WIDTH-1:0]    abphase_in,
  input  logic                     abphase_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_sof,
  output logic                     out_eol,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LW-1:0]            fifo_level,
  output logic                     overflow,
  output logic [OVF_CNT_WIDTH-1:0] drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int EW = DATA_WIDTH + 2;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;

  logic          vs_q;
  logic          vs_edge;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic          full;
  logic          empty;
  logic          rd_en;
  logic          wr_en;
  logic          drop;
  logic [CW-1:0] col_eff;
  logic [RW-1:0] row_eff;
  logic          tag_sof;
  logic          tag_eol;
  logic [EW-1:0] head;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign rd_en   = !empty && out_ready;
  assign wr_en   = abphase_valid && (!full || rd_en);
  assign drop    = abphase_valid && !wr_en;

  // The frame-start pulse overrides the position for this cycle's sample.
  assign col_eff = vs_edge ? '0 : col;
  assign row_eff = vs_edge ? '0 : row;
  assign tag_sof = (col_eff == '0) && (row_eff == '0);
  assign tag_eol = (col_eff == CW'(IMG_W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_q    <= 1'b0;
      vs_edge <= 1'b0;
    end else begin
      vs_q    <= frame_vsync;
      vs_edge <= frame_vsync && !vs_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (abphase_valid) begin
      if (col_eff == CW'(IMG_W - 1)) begin
        col <= '0;
        if (row_eff == RW'(IMG_H - 1))
          row <= '0;
        else
          row <= row_eff + 1'b1;
      end else begin
        col <= col_eff + 1'b1;
        row <= row_eff;
      end
    end else if (vs_edge) begin
      col <= '0;
      row <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= {tag_sof, tag_eol, abphase_in};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (vs_edge) begin
      overflow <= drop;
      drop_cnt <= drop ? OVF_CNT_WIDTH'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign head       = mem[rd_ptr];
  assign out_valid  = !empty;
  assign out_data   = empty ? '0 : head[DATA_WIDTH-1:0];
  assign out_eol    = !empty && head[DATA_WIDTH];
  assign out_sof    = !empty && head[DATA_WIDTH+1];
  assign fifo_level = level;

endmodule

// File: tb/tb_abphase_stream_packer.sv
// Scoreboard bench for abphase_stream_packer with a small
// geometry (4x2) and a 16-entry FIFO.
module tb_abphase_stream_packer;

  localparam int DW  = 32;
  localparam int W   = 4;
  localparam int H   = 2;
  localparam int D   = 16;
  localparam int CWD = 16;
  localparam int LW  = $clog2(D) + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           frame_vsync = 1'b0;
  logic [DW-1:0]  abphase_in = '0;
  logic           abphase_valid = 1'b0;
  logic [DW-1:0]  out_data;
  logic           out_sof;
  logic           out_eol;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [LW-1:0]  fifo_level;
  logic           overflow;
  logic [CWD-1:0] drop_cnt;

  int total = 0;
  int bad = 0;

  abphase_stream_packer #(
    .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H),
    .FIFO_DEPTH(D), .OVF_CNT_WIDTH(CWD)
  ) dut (
    .clk(clk), .rst(rst), .frame_vsync(frame_vsync),
    .abphase_in(abphase_in), .abphase_valid(abphase_valid),
    .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol),
    .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, act, exp, $time);
    end
  endtask

  // Reference model and scoreboard, evaluated mid-cycle.
  logic [DW+1:0]  q[$];
  logic [DW+1:0]  ent;
  int             mc, mr, ce, re;
  logic           p1, p2, pulse, rd, wr;
  logic           movf;
  logic [CWD-1:0] mdrop;

  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      mc = 0; mr = 0; p1 = 0; p2 = 0;
      movf = 0; mdrop = '0;
    end else begin
      pulse = p1 && !p2;
      chk("valid", 64'(out_valid), 64'(q.size() != 0));
      chk("level", 64'(fifo_level), 64'(q.size()));
      chk("ovf", 64'(overflow), 64'(movf));
      chk("drop", 64'(drop_cnt), 64'(mdrop));
      if (q.size() != 0) begin
        ent = q[0];
        chk("data", 64'(out_data), 64'(ent[DW-1:0]));
        chk("eol", 64'(out_eol), 64'(ent[DW]));
        chk("sof", 64'(out_sof), 64'(ent[DW+1]));
      end
      rd = (q.size() != 0) && out_ready;
      wr = abphase_valid && (q.size() < D || rd);
      ce = pulse ? 0 : mc;
      re = pulse ? 0 : mr;
      if (pulse) begin
        movf = 0;
        mdrop = '0;
      end
      if (rd)
        void'(q.pop_front());
      if (abphase_valid) begin
        if (wr)
          q.push_back({ce == 0 && re == 0, ce == W - 1, abphase_in});
        else begin
          movf = 1;
          if (mdrop != '1) mdrop = mdrop + 1'b1;
        end
        if (ce == W - 1) begin
          mc = 0;
          mr = (re == H - 1) ? 0 : re + 1;
        end else begin
          mc = ce + 1;
          mr = re;
        end
      end else if (pulse) begin
        mc = 0;
        mr = 0;
      end
      p2 = p1;
      p1 = frame_vsync;
    end
  end

  task automatic px(input logic v, input logic [DW-1:0] d);
    abphase_valid = v;
    abphase_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    frame_vsync = 1'b1;
    px(0, 0);
    px(0, 0);
    frame_vsync = 1'b0;
    px(0, 0);
    px(0, 0);
    px(0, 0);
  endtask

  task automatic drain(input int until_lvl);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (fifo_level != LW'(until_lvl) && n < 40) begin
      px(0, 0);
      n++;
    end
    chk("drain_bound", 64'(n < 40), 64'(1));
  endtask

  bit rp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    px(0, 0);
    #2;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_level", 64'(fifo_level), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_drop", 64'(drop_cnt), 64'(0));
    px(0, 0);
    rst = 1'b1;
    px(0, 0);

    out_ready = 1'b1;
    vs_pulse();
    for (int i = 1; i <= 8; i++) px(1, DW'(i));
    for (int i = 0; i < 4; i++) px(0, 0);
    chk("t1_ovf", 64'(overflow), 64'(0));

    out_ready = 1'b0;
    vs_pulse();
    for (int i = 0; i < 20; i++) px(1, DW'(101 + i));
    chk("t2_level", 64'(fifo_level), 64'(16));
    chk("t2_ovf", 64'(overflow), 64'(1));
    chk("t2_drop", 64'(drop_cnt), 64'(4));

    out_ready = 1'b1;
    px(1, 200);
    chk("t3_level", 64'(fifo_level), 64'(16));
    chk("t3_drop", 64'(drop_cnt), 64'(4));
    drain(0);
    chk("t3_empty", 64'(out_valid), 64'(0));

    for (int i = 0; i < 8; i++) begin
      out_ready = rp[i % 4];
      px(1, DW'(300 + i));
    end
    drain(0);

    out_ready = 1'b0;
    vs_pulse();
    for (int i = 0; i < 18; i++) px(1, DW'(400 + i));
    chk("t5_ovf_pre", 64'(overflow), 64'(1));
    chk("t5_drop_pre", 64'(drop_cnt), 64'(2));
    vs_pulse();
    chk("t5_ovf_clr", 64'(overflow), 64'(0));
    chk("t5_drop_clr", 64'(drop_cnt), 64'(0));
    chk("t5_kept", 64'(fifo_level), 64'(16));
    out_ready = 1'b1;
    px(1, 500);
    drain(1);
    chk("t5_data", 64'(out_data), 64'(500));
    chk("t5_sof", 64'(out_sof), 64'(1));
    drain(0);

    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) px(1, DW'(600 + i));
    px(0, 0);
    chk("t6_level", 64'(fifo_level), 64'(5));
    #2;
    rst = 1'b0;
    #1;
    chk("t6_valid", 64'(out_valid), 64'(0));
    chk("t6_level0", 64'(fifo_level), 64'(0));
    chk("t6_drop", 64'(drop_cnt), 64'(0));
    chk("t6_ovf", 64'(overflow), 64'(0));
    px(0, 0);
    px(0, 0);
    rst = 1'b1;
    px(0, 0);
    px(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
